alu_rr_scheduler: RTL
=====================

// Module: alu_rr_scheduler
// PURPOSE
//  Shares one 32-bit MIPS ALU between NUM_REQ requesters (e.g. EX stage, branch unit, debug port).
//  Round-robin arbitration, valid/ready request channels and one registered response slot with requester ID.
//  The ALU sits outside this block; the block drives its operands and op and samples result/zero/overflow.
//  Throughput is one op per cycle; latency is one cycle.
// PARAMETERS
//  NUM_REQ   4   number of requesters, 2..8
//  ID_W      2   requester ID width, $clog2(NUM_REQ)
//  CNT_W     16  width of the saturating overflow counter
// PORTS
//  clk            in   1            clock, rising edge
//  rst_n          in   1            asynchronous active-low reset
//  req_valid      in   NUM_REQ      per-requester request valid
//  req_ready      out  NUM_REQ      per-requester accept, one-hot or zero
//  req_src1       in   NUM_REQ x32  operand A per requester
//  req_src2       in   NUM_REQ x32  operand B per requester
//  req_op         in   NUM_REQ x4   ALU operation per requester (alu_pkg encoding)
//  alu_src1_o     out  32           to ALU operand A
//  alu_src2_o     out  32           to ALU operand B
//  alu_op_o       out  4            to ALU operation select
//  alu_result_i   in   32           from ALU result
//  alu_zero_i     in   1            from ALU zero flag
//  alu_ovf_i      in   1            from ALU overflow flag
//  rsp_valid      out  1            response valid
//  rsp_ready      in   1            response accept
//  rsp_id         out  ID_W         index of the requester that owns the response
//  rsp_result     out  32           captured result
//  rsp_zero       out  1            captured zero flag
//  rsp_ovf        out  1            captured overflow flag, masked per op class
//  ovf_count      out  CNT_W        saturating count of responses captured with rsp_ovf=1
// BEHAVIOUR
//  Reset:
//   - rsp_valid=0; rsp_id, rsp_result, rsp_zero and rsp_ovf are 0.
//   - ovf_count=0; rr_ptr=0; FSM enters EMPTY.
//   - A response held at reset is lost.
//  FSM states:
//   - EMPTY: response slot free.
//   - FULL: rsp_valid=1.
//  slot_free = (state==EMPTY) | (rsp_valid & rsp_ready).
//  Grant:
//   - Combinational, only when slot_free.
//   - Winner is the first i with req_valid[i] set, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - req_ready = one-hot(winner), or 0 if slot is not free or there is no request.
//   - req_ready must not depend on req_valid of other requesters except through the arbitration.
//  ALU drive:
//   - In the grant cycle, alu_src1_o, alu_src2_o and alu_op_o come from the winner.
//   - Otherwise they are all 0 (op 0 = AND).
//  Capture (edge after grant):
//   - rsp_valid=1, rsp_id=winner.
//   - rsp_result=alu_result_i, rsp_zero=alu_zero_i.
//   - rsp_ovf = alu_ovf_i & op[1] (AND/OR never report overflow).
//   - rr_ptr = (winner+1) mod NUM_REQ.
//  Transitions:
//   - EMPTY -> FULL on grant.
//   - FULL -> FULL on drain and grant in the same cycle (back-to-back).
//   - FULL -> EMPTY on drain with no grant.
//   - FULL holds while rsp_ready=0; all rsp_* stay stable and req_ready=0.
//  Latency:
//   - Accept in cycle T gives rsp_valid in T+1.
//   - With rsp_ready held high, one response per cycle is sustained.
//  rr_ptr advances only on a grant. A requester dropping req_valid without a handshake is legal and costs nothing.
//  ovf_count increments on each capture with rsp_ovf=1 and saturates at all-ones.
//  Requesters must hold req_src*/req_op stable while req_valid=1 and req_ready=0.
// STRUCTURE
//  alu_pkg:
//   - ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100.
//   - typedef alu_op_t (logic [3:0]).
//   - typedef sched_state_e {EMPTY, FULL}.
//  Sub-module rr_arbiter #(N):
//   - inputs: req, ptr, en.
//   - outputs: one-hot gnt, gnt_idx, any.
//   - reused for other shared resources.
// TESTING
//  1 After reset, req_valid=4'b0001 with ALU_ADD 5,7: req_ready=0001 in the same cycle;
//    next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
//  2 req_valid=4'b1111 held, rsp_ready=1: grants 0,1,2,3,0 in consecutive cycles.
//    rsp_id follows the same sequence with no bubble.
//  3 Backpressure: rsp_ready=0 for 3 cycles with a response held.
//    req_ready=0 and rsp_* stable throughout. On release, drain and the next grant occur in the same cycle.
//  4 ALU_ADD 0x7FFFFFFF+1 from req 2 (alu_ovf_i=1): rsp_ovf=1 and ovf_count goes 0->1.
//    ALU_OR with alu_ovf_i forced 1: rsp_ovf=0 and ovf_count is unchanged.
//  5 ALU_SUB 9,9: rsp_zero=1. Drive 2^CNT_W+1 overflowing ADDs: ovf_count saturates at all-ones.
//  6 Assert rst_n low while FULL with rr_ptr=2:
//    rsp_valid=0 immediately (asynchronously); after release the first grant scans from requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : ALU operation encodings and scheduler state type.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND = 4'b0000;
    localparam alu_op_t ALU_OR  = 4'b0001;
    localparam alu_op_t ALU_ADD = 4'b0010;
    localparam alu_op_t ALU_SUB = 4'b0110;
    localparam alu_op_t ALU_SLT = 4'b0111;
    localparam alu_op_t ALU_NOR = 4'b1100;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } sched_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_scheduler_if
// Brief    : Request, ALU and response channels of the shared-ALU scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_rr_scheduler_if
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0][31:0]     req_src1;
    logic [NUM_REQ-1:0][31:0]     req_src2;
    logic [NUM_REQ-1:0][3:0]      req_op;

    logic [31:0]                  alu_src1_o;
    logic [31:0]                  alu_src2_o;
    alu_op_t                      alu_op_o;
    logic [31:0]                  alu_result_i;
    logic                         alu_zero_i;
    logic                         alu_ovf_i;

    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [ID_W-1:0]              rsp_id;
    logic [31:0]                  rsp_result;
    logic                         rsp_zero;
    logic                         rsp_ovf;
    logic [CNT_W-1:0]             ovf_count;

    modport slave (
        input  req_valid, req_src1, req_src2, req_op,
        input  alu_result_i, alu_zero_i, alu_ovf_i, rsp_ready,
        output req_ready, alu_src1_o, alu_src2_o, alu_op_o,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_ovf, ovf_count
    );

    modport master (
        output req_valid, req_src1, req_src2, req_op,
        output alu_result_i, alu_zero_i, alu_ovf_i, rsp_ready,
        input  req_ready, alu_src1_o, alu_src2_o, alu_op_o,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_ovf, ovf_count
    );

endinterface : alu_rr_scheduler_if
`default_nettype wire

// File: rtl/alu_rr_scheduler_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter scanning upward from i_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    input  wire logic             i_en,
    output logic      [N-1:0]     o_gnt,
    output logic      [IDX_W-1:0] o_gnt_idx,
    output logic                  o_any
);
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the closest requester wins last.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (i_en && i_req[w_idx]) begin
                o_any        = 1'b1;
                o_gnt_idx    = w_idx;
                o_gnt        = '0;
                o_gnt[w_idx] = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_scheduler
// Brief    : Round-robin sharing of one external ALU with a one-deep response slot.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    alu_rr_scheduler_if.slave bus
);
    sched_state_e      r_state;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [31:0]       r_rsp_result;
    logic              r_rsp_zero;
    logic              r_rsp_ovf;
    logic [CNT_W-1:0]  r_ovf_count;
    logic [ID_W-1:0]   r_ptr;

    logic              w_slot_free;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]   w_gnt_idx;
    logic              w_grant;
    logic              w_ovf;
    logic [ID_W-1:0]   w_ptr_next;

    assign w_slot_free = (r_state == EMPTY) | (r_rsp_valid & bus.rsp_ready);

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .i_req     (bus.req_valid),
        .i_ptr     (r_ptr),
        .i_en      (w_slot_free),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_grant)
    );

    assign bus.req_ready  = w_gnt;
    assign bus.alu_src1_o = w_grant ? bus.req_src1[w_gnt_idx] : 32'd0;
    assign bus.alu_src2_o = w_grant ? bus.req_src2[w_gnt_idx] : 32'd0;
    assign bus.alu_op_o   = w_grant ? bus.req_op[w_gnt_idx]   : ALU_AND;

    // Logic ops (op[1]=0) never report overflow, whatever the ALU flags.
    assign w_ovf      = bus.alu_ovf_i & bus.alu_op_o[1];
    assign w_ptr_next = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= EMPTY;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_ovf    <= 1'b0;
            r_ovf_count  <= '0;
            r_ptr        <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_grant) begin
                        r_state     <= FULL;
                        r_rsp_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (bus.rsp_ready && !w_grant) begin
                        r_state     <= EMPTY;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_rsp_valid <= 1'b0;
                end
            endcase
            if (w_grant) begin
                r_rsp_id     <= w_gnt_idx;
                r_rsp_result <= bus.alu_result_i;
                r_rsp_zero   <= bus.alu_zero_i;
                r_rsp_ovf    <= w_ovf;
                r_ptr        <= w_ptr_next;
                if (w_ovf && (r_ovf_count != '1)) begin
                    r_ovf_count <= r_ovf_count + CNT_W'(1);
                end
            end
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_ovf    = r_rsp_ovf;
    assign bus.ovf_count  = r_ovf_count;

endmodule : alu_rr_scheduler
`default_nettype wire
